mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store front end between the multicycle datapath and the unified word-addressed Memory.
//  Memory reads are combinational. Memory writes are whole 32-bit words on posedge clk.
//  This block adds RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW semantics:
//   - sub-word stores via read-modify-write;
//   - load lane extraction with sign/zero extension;
//   - misalignment and illegal-size detection.
// PARAMETERS
//  ADDR_W  32  byte-address width; memAdr width
//  DATA_W  32  data width; only 32 is supported
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  req        in   1       access request, sampled only in IDLE
//  we         in   1       1 = store, 0 = load
//  funct3     in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  addr       in   ADDR_W  byte address
//  wdata      in   DATA_W  store data, low bits used for B/H
//  rdata      out  DATA_W  extended load result, valid while ready=1
//  ready      out  1       one-cycle completion pulse
//  busy       out  1       state != IDLE
//  misaligned out  1       with ready: H with addr[0]=1, or W with addr[1:0]!=0
//  illegal    out  1       with ready: funct3 in {011,110,111}, or store with 1xx
//  memAdr     out  ADDR_W  {addr_q[ADDR_W-1:2],2'b00} in every state
//  writeData  out  DATA_W  merged word; driven only in WR
//  memWrite   out  1       (state==WR) & ~rst
//  readData   in   DATA_W  combinational word from Memory
// BEHAVIOUR
//  Reset: all outputs 0 on the cycle after rst.
//   - state=IDLE.
//   - addr_q, wdata_q, word_q, rdata cleared.
//   - rst high in any state aborts the access: no memWrite that cycle, no ready pulse.
//  States: IDLE, RD, WR, DONE.
//  IDLE: on req=1, latch we/funct3/addr/wdata. Next state:
//   - fault (misaligned|illegal) -> DONE; no memory access.
//   - load -> RD.
//   - SW -> WR.
//   - SB/SH -> RD.
//  RD:
//   - word_q <= readData.
//   - load -> DONE with rdata computed from readData.
//   - SB/SH -> WR.
//  WR:
//   - memWrite=1.
//   - SW: writeData=wdata_q.
//   - SB: word_q with byte lane addr_q[1:0] replaced by wdata_q[7:0].
//   - SH: word_q with half addr_q[1] replaced by wdata_q[15:0].
//   - -> DONE.
//  DONE: ready=1 for exactly one cycle -> IDLE. A new req is accepted on the following cycle.
//  Latency, req sampled at edge N:
//   - load: ready during cycle N+2.
//   - SW: memWrite in N+1, ready N+2.
//   - SB/SH: memWrite in N+2, ready N+3.
//   - fault: ready N+1, misaligned/illegal=1, rdata=0, no memWrite ever.
//  Load extraction:
//   - B/BU: byte addr_q[1:0] sign/zero-extended.
//   - H/HU: half addr_q[1] sign/zero-extended.
//   - W: word unchanged.
//  rdata holds its value until the next load completes. Stores and faults do not alter rdata (faults force 0).
//  req, inputs and input changes while busy=1 are ignored; latched copies are used throughout.
//  Flags misaligned/illegal are meaningful only while ready=1, and 0 otherwise.
// TESTING
//  - LW @0x10, mem[0x10..13]=DE AD BE EF -> ready at N+2, rdata=0xEFBEADDE, memWrite never 1.
//  - LB @0x13 (word 0x80FF7F01) -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU @0x12 -> 0x000080FF.
//  - SB wdata=0x000000AA @0x21 over word 0x11223344 -> one memWrite at N+2, writeData=0x1122AA44, ready N+3.
//  - LH @0x05, SW @0x22 -> ready N+1, misaligned=1, no memWrite; funct3=011 -> illegal=1.
//  - rst during WR of SH -> memWrite=0 that cycle, memory unchanged, ready never pulses, next req served normally.
//  - back-to-back: req held high -> second access starts the cycle after ready; busy inputs changed mid-access ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V load/store front end for a word-addressed memory.
// Adds byte/half/word loads with sign or zero extension, sub-word stores by
// read-modify-write, and detection of misaligned or illegal accesses.
// Handshake: req is sampled only while busy=0. Every accepted request ends
// with exactly one ready pulse, which carries rdata and the fault flags.
// A reset while busy drops the access: there is no write and no ready pulse.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              misaligned,
    output logic              illegal,
    output logic [ADDR_W-1:0] memAdr,
    output logic [DATA_W-1:0] writeData,
    output logic              memWrite,
    input  logic [DATA_W-1:0] readData,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;

    logic              in_illegal;
    logic              in_misaligned;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merged;

    // Classify the incoming request; only meaningful while IDLE samples req.
    always_comb begin
        in_illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
        in_misaligned = 1'b0;
        case (funct3)
            3'b001, 3'b101: in_misaligned = addr[0];
            3'b010:         in_misaligned = (addr[1:0] != 2'b00);
            default:        in_misaligned = 1'b0;
        endcase
    end

    // Pick the addressed lane from the memory word and extend it.
    always_comb begin
        lane_byte = readData[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? readData[31:16] : readData[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_val = {24'd0, lane_byte};
            3'b101:  load_val = {16'd0, lane_half};
            default: load_val = readData;
        endcase
    end

    // Merge sub-word store data into the word captured during RD.
    always_comb begin
        merged = word_q;
        case (f3_q)
            3'b000:  merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b001:  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign memAdr    = {addr_q[ADDR_W-1:2], 2'b00};
    // Reset gates the write strobe combinationally so an aborted WR never commits.
    assign memWrite  = (state == WR) & ~rst;
    assign writeData = (state == WR) ? merged : '0;

    // Access sequencer: latches the request, walks RD/WR, and registers the result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata      <= '0;
            ready      <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            ready      <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (in_illegal || in_misaligned) begin
                            // Faulting access completes at once with no memory traffic.
                            state      <= DONE;
                            ready      <= 1'b1;
                            misaligned <= in_misaligned;
                            illegal    <= in_illegal;
                            rdata      <= '0;
                        end else if (we && (funct3 == 3'b010)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    word_q <= readData;
                    if (!we_q) begin
                        rdata <= load_val;
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= WR;
                    end
                end
                WR: begin
                    ready <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a small
// word-addressed memory model, with hand-computed expected values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        misaligned;
    logic        illegal;
    logic [31:0] memAdr;
    logic [31:0] writeData;
    logic        memWrite;
    logic [31:0] readData;
    logic [1:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int wc0;

    logic [31:0] mem [0:63];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .busy       (busy),
        .misaligned (misaligned),
        .illegal    (illegal),
        .memAdr     (memAdr),
        .writeData  (writeData),
        .memWrite   (memWrite),
        .readData   (readData),
        .state_dbg  (state_dbg)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Memory model: combinational read, whole-word write on posedge.
    assign readData = mem[memAdr[7:2]];
    always @(posedge clk) if (memWrite) mem[memAdr[7:2]] <= writeData;

    // Count write cycles, sampled mid-cycle.
    always @(negedge clk) if (memWrite) wr_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        mem[idx] <= v;
    endtask

    // Present a request for one edge; returns #1 after the sampling edge.
    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] exp);
        issue(1'b0, f, a, 32'h0, 1'b0);
        step();
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_rdata"}, rdata, exp);
        step();
    endtask

    task automatic do_fault(input string tag, input logic w, input logic [2:0] f,
                            input logic [31:0] a, input logic mis, input logic ill);
        issue(w, f, a, 32'h5555_5555, 1'b0);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_mis"}, {31'd0, misaligned}, {31'd0, mis});
        chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, ill});
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_memwrite"}, {31'd0, memWrite}, 32'd0);
        step();
        chk({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
        chk({tag, "_flags_drop"}, {30'd0, misaligned, illegal}, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[4] <= 32'hEFBEADDE;
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;

        // Reset state
        repeat (3) step();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", {28'd0, ready, busy, misaligned, illegal}, 32'h0);
        chk("rst_memadr", memAdr, 32'h0);
        chk("rst_wdata", writeData, 32'h0);
        chk("rst_memwrite", {31'd0, memWrite}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LW @0x10: ready at N+2, no write
        wc0 = wr_count;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        chk("lw_busy", {31'd0, busy}, 32'd1);
        chk("lw_ready_n1", {31'd0, ready}, 32'd0);
        chk("lw_memadr", memAdr, 32'h10);
        step();
        chk("lw_ready_n2", {31'd0, ready}, 32'd1);
        chk("lw_rdata", rdata, 32'hEFBEADDE);
        chk("lw_flags", {30'd0, misaligned, illegal}, 32'd0);
        step();
        chk("lw_ready_n3", {31'd0, ready}, 32'd0);
        chk("lw_idle", {31'd0, busy}, 32'd0);
        chk("lw_hold", rdata, 32'hEFBEADDE);
        chk("lw_nowrite", wr_count, wc0);

        // Lane extraction on word 0x80FF7F01
        poke(4, 32'h80FF7F01);
        do_load("lb13", 3'b000, 32'h13, 32'hFFFFFF80);
        do_load("lbu13", 3'b100, 32'h13, 32'h00000080);
        do_load("lhu12", 3'b101, 32'h12, 32'h000080FF);
        do_load("lh12", 3'b001, 32'h12, 32'hFFFF80FF);
        do_load("lb10", 3'b000, 32'h10, 32'h00000001);
        do_load("lh10", 3'b001, 32'h10, 32'h00007F01);

        // SB 0xAA @0x21 over 0x11223344
        poke(8, 32'h11223344);
        wc0 = wr_count;
        issue(1'b1, 3'b000, 32'h21, 32'h000000AA, 1'b0);
        chk("sb_n1_nowrite", {31'd0, memWrite}, 32'd0);
        step();
        chk("sb_n2_write", {31'd0, memWrite}, 32'd1);
        chk("sb_n2_data", writeData, 32'h1122AA44);
        chk("sb_n2_adr", memAdr, 32'h20);
        chk("sb_n2_ready", {31'd0, ready}, 32'd0);
        step();
        chk("sb_n3_ready", {31'd0, ready}, 32'd1);
        chk("sb_n3_nowrite", {31'd0, memWrite}, 32'd0);
        chk("sb_rdata_hold", rdata, 32'h00007F01);
        chk("sb_mem", mem[8], 32'h1122AA44);
        chk("sb_one_write", wr_count, wc0 + 1);
        step();

        // SW @0x24: write in N+1, ready N+2
        issue(1'b1, 3'b010, 32'h24, 32'hCAFEF00D, 1'b0);
        chk("sw_n1_write", {31'd0, memWrite}, 32'd1);
        chk("sw_n1_data", writeData, 32'hCAFEF00D);
        step();
        chk("sw_n2_ready", {31'd0, ready}, 32'd1);
        chk("sw_mem", mem[9], 32'hCAFEF00D);
        chk("sw_rdata_hold", rdata, 32'h00007F01);
        step();

        // Faults: ready at N+1, flags set, rdata forced 0, no write
        wc0 = wr_count;
        do_fault("lh05", 1'b0, 3'b001, 32'h05, 1'b1, 1'b0);
        do_fault("sw22", 1'b1, 3'b010, 32'h22, 1'b1, 1'b0);
        do_fault("f011", 1'b0, 3'b011, 32'h10, 1'b0, 1'b1);
        do_fault("sbu", 1'b1, 3'b100, 32'h10, 1'b0, 1'b1);
        chk("fault_nowrite", wr_count, wc0);
        chk("fault_mem", mem[1], 32'h0);

        // Reset during WR of SH aborts the store
        poke(12, 32'hAABBCCDD);
        wc0 = wr_count;
        issue(1'b1, 3'b001, 32'h32, 32'h00001234, 1'b0);
        step();
        chk("shrst_wr_pre", {31'd0, memWrite}, 32'd1);
        rst = 1'b1;
        #1;
        chk("shrst_gated", {31'd0, memWrite}, 32'd0);
        step();
        chk("shrst_idle", {30'd0, ready, busy}, 32'd0);
        chk("shrst_memadr", memAdr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("shrst_noready", {31'd0, ready}, 32'd0);
        end
        chk("shrst_mem", mem[12], 32'hAABBCCDD);
        chk("shrst_nowrite", wr_count, wc0);

        // Next SH served normally
        issue(1'b1, 3'b001, 32'h32, 32'h00001234, 1'b0);
        step();
        chk("sh_write", {31'd0, memWrite}, 32'd1);
        chk("sh_data", writeData, 32'h1234CCDD);
        step();
        chk("sh_ready", {31'd0, ready}, 32'd1);
        chk("sh_mem", mem[12], 32'h1234CCDD);
        step();

        // Back-to-back with req held and inputs changed mid-access
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        addr = 32'h20; funct3 = 3'b100;
        chk("b2b_adr_latched", memAdr, 32'h10);
        step();
        chk("b2b_first_ready", {31'd0, ready}, 32'd1);
        chk("b2b_first_rdata", rdata, 32'h80FF7F01);
        step();
        chk("b2b_gap_idle", {30'd0, ready, busy}, 32'd0);
        step();
        req = 1'b0;
        chk("b2b_second_busy", {31'd0, busy}, 32'd1);
        chk("b2b_second_adr", memAdr, 32'h20);
        step();
        chk("b2b_second_ready", {31'd0, ready}, 32'd1);
        chk("b2b_second_rdata", rdata, 32'h00000044);
        step();
        chk("b2b_end_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
